stream_fifo: RTL and testbench
==============================

// Module: stream_fifo
// PURPOSE
// - Parametrised, first-word-fall-through FIFO with valid/ready handshakes on both sides.
// - Adds occupancy count, almost-full/almost-empty flags and synchronous flush.
// - General buffering stage between streaming producers and consumers in generated datapaths.
// PARAMETERS
// - DATA_WIDTH    8   width of each stored word (>=1)
// - DEPTH         4   number of entries; power of two, >=2
// - AFULL_LEVEL   3   io_almost_full asserted when count >= AFULL_LEVEL (1..DEPTH)
// - AEMPTY_LEVEL  1   io_almost_empty asserted when count <= AEMPTY_LEVEL (0..DEPTH-1)
// - Derived: AW = log2(DEPTH); CW = AW+1.
// PORTS
// - clk              in   1           single clock; all state updates on rising edge
// - reset            in   1           asynchronous active-low reset (0 = in reset)
// - io_enq_valid     in   1           producer offers io_enq_data
// - io_enq_ready     out  1           FIFO can accept a word this cycle
// - io_enq_data      in   DATA_WIDTH  write data
// - io_deq_valid     out  1           io_deq_data holds the oldest entry
// - io_deq_ready     in   1           consumer takes the word this cycle
// - io_deq_data      out  DATA_WIDTH  oldest entry (fall-through)
// - io_flush         in   1           synchronous discard of all contents
// - io_count         out  CW          current occupancy, 0..DEPTH
// - io_almost_full   out  1           count >= AFULL_LEVEL
// - io_almost_empty  out  1           count <= AEMPTY_LEVEL
// BEHAVIOUR
// - Pointers wr_ptr/rd_ptr are CW bits wide. Low AW bits address storage; the MSB is the wrap flag.
// - empty = (wr_ptr == rd_ptr).
// - full = low AW bits equal AND MSBs differ.
// - io_enq_ready = !full; io_deq_valid = !empty. Both depend only on state, never on inputs.
// - enq fires = io_enq_valid & io_enq_ready.
//   - mem[wr_ptr[AW-1:0]] <= io_enq_data; wr_ptr <= wr_ptr+1 (mod 2^CW).
// - deq fires = io_deq_valid & io_deq_ready; rd_ptr <= rd_ptr+1 (mod 2^CW).
// - io_deq_data = mem[rd_ptr[AW-1:0]], combinational read.
//   - Valid whenever io_deq_valid = 1.
//   - Value is don't-care when empty.
// - Latency: a word written at edge N is visible on io_deq_data (io_deq_valid=1) in the cycle after edge N.
//   - No same-cycle empty bypass.
// - Simultaneous enq+deq (neither full nor empty): both fire; count unchanged.
// - Full: enq blocked by ready=0; a deq in the same cycle does not let an enq through (no full bypass).
// - Empty: io_deq_ready is ignored; pointers unchanged.
// - io_enq_valid with ready=0: word not taken; producer must hold it. Not an error.
// - io_count = wr_ptr - rd_ptr (CW-bit subtraction, wrap-safe).
//   - Flags are combinational compares on io_count.
// - io_flush=1: at next edge wr_ptr <= 0, rd_ptr <= 0.
//   - Overrides any enq/deq in the same cycle; the enqueued word is dropped.
//   - The handshake outputs still show their pre-flush values that cycle.
// - Reset (reset=0, async): pointers -> 0 immediately.
//   - io_enq_ready=1, io_deq_valid=0, io_count=0, io_almost_full=0, io_almost_empty=1.
//   - Storage is not reset.
//   - Reset mid-transfer discards all contents; first enq after release lands at address 0.
// STRUCTURE
// - Shared package stream_pkg:
//   - clog2 function;
//   - parameter legality checks (DEPTH power of two, level ranges);
//   - common handshake-fire macro/typedef, reused by other stream blocks.
// - Sub-module fifo_ram #(DATA_WIDTH, DEPTH): sync write, async read, no reset.
// - Top holds pointers, flags and count only.
// TESTING (DATA_WIDTH=8, DEPTH=4, AFULL=3, AEMPTY=1 unless stated)
// 1. Reset then idle.
//    - enq_ready=1, deq_valid=0, count=0, almost_empty=1, almost_full=0.
// 2. Fill and drain in order.
//    - Enq 0x11,0x22,0x33,0x44 with deq_ready=0 -> count 1..4; almost_full from count 3; enq_ready=0 at 4.
//    - Then deq_ready=1 -> outputs 0x11..0x44 in order; deq_valid=0 after the 4th.
// 3. Full stall.
//    - At count=4, enq_valid=1 with 0x55 and deq_ready=1 together.
//    - That cycle: only 0x11 leaves; count=3.
//    - Next cycle: 0x55 accepted; final order 0x22,0x33,0x44,0x55.
// 4. Concurrent streaming with wrap.
//    - 20 words, both sides valid/ready=1 after the first enq.
//    - Count stays 1; pointers wrap the MSB several times.
//    - Output sequence equals input; no loss or duplication.
// 5. Flush priority.
//    - At count=2, assert io_flush together with enq 0x77 and deq_ready=1.
//    - Next cycle: count=0, deq_valid=0.
//    - Next enq 0x88 appears first at the output.
// 6. Async reset mid-operation.
//    - Drop reset between edges at count=3 -> outputs reach reset values before the next edge.
//    - After release, enq 0x99 -> deq_data=0x99, count=1.

Source files
------------

// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg
//
// Definitions shared by the streaming blocks:
//   clog2          - constant log2 (rounded up), used to size addresses
//   is_pow2        - true for powers of two >= 2
//   fifo_params_ok - legality check for stream_fifo parameters
//   hs_fire        - valid/ready handshake "transfer happens" term
// ---------------------------------------------------------------------------
package stream_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit fifo_params_ok(input int data_width, input int depth,
                                        input int afull, input int aempty);
    return (data_width >= 1) && is_pow2(depth) &&
           (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

  // A beat transfers on a rising edge exactly when both sides agree.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
//
// Storage array for stream_fifo: synchronous write, asynchronous read.
// Ports:
//   clk      - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module fifo_ram
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; the pointers alone decide which entries
  // are live, so clearing storage would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
//
// First-word-fall-through FIFO with valid/ready handshakes on both sides,
// occupancy count, almost-full/almost-empty flags and synchronous flush.
// Ports:
//   clk             - clock, rising edge
//   reset           - asynchronous active-low reset
//   io_enq_valid    - producer offers io_enq_data
//   io_enq_ready    - FIFO not full
//   io_enq_data     - write data
//   io_deq_valid    - FIFO not empty; io_deq_data is the oldest entry
//   io_deq_ready    - consumer takes the word
//   io_deq_data     - oldest entry
//   io_flush        - discard all contents at the next edge
//   io_count        - occupancy 0..DEPTH
//   io_almost_full  - io_count >= AFULL_LEVEL
//   io_almost_empty - io_count <= AEMPTY_LEVEL
// ---------------------------------------------------------------------------
module stream_fifo
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_LEVEL  = 3,
  parameter int AEMPTY_LEVEL = 1,
  localparam int AW          = clog2(DEPTH),
  localparam int CW          = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_enq_valid,
  output logic                  io_enq_ready,
  input  logic [DATA_WIDTH-1:0] io_enq_data,
  output logic                  io_deq_valid,
  input  logic                  io_deq_ready,
  output logic [DATA_WIDTH-1:0] io_deq_data,
  input  logic                  io_flush,
  output logic [CW-1:0]         io_count,
  output logic                  io_almost_full,
  output logic                  io_almost_empty
);

  if (!fifo_params_ok(DATA_WIDTH, DEPTH, AFULL_LEVEL, AEMPTY_LEVEL)) begin : g_bad_params
    $error("stream_fifo: illegal parameter combination");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          empty, full;
  logic          enq_fire, deq_fire;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Handshake outputs come from state only, so no comb path input->ready.
  assign io_enq_ready = !full;
  assign io_deq_valid = !empty;

  assign enq_fire = hs_fire(io_enq_valid, io_enq_ready);
  assign deq_fire = hs_fire(io_deq_valid, io_deq_ready);

  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (io_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + CW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // A flushed cycle's enqueue is dropped, so it must not touch storage.
  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (enq_fire & ~io_flush),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (io_enq_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (io_deq_data)
  );

  // Modular subtraction stays correct across pointer wrap.
  assign io_count        = wr_ptr_q - rd_ptr_q;
  assign io_almost_full  = (io_count >= CW'(AFULL_LEVEL));
  assign io_almost_empty = (io_count <= CW'(AEMPTY_LEVEL));

endmodule

// File: tb/tb_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_fifo
//
// Directed stimulus for stream_fifo (DATA_WIDTH=8, DEPTH=4, AFULL=3,
// AEMPTY=1). A queue-based reference model tracks the expected contents and
// a compare process checks every DUT output against it on each falling edge;
// hand-computed literal checks in the stimulus pin the model itself.
// ---------------------------------------------------------------------------
module tb_stream_fifo;

  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int AFULL  = 3;
  localparam int AEMPTY = 1;
  localparam int CW     = 3;

  logic          clk;
  logic          reset;
  logic          enq_valid, enq_ready;
  logic [DW-1:0] enq_data;
  logic          deq_valid, deq_ready;
  logic [DW-1:0] deq_data;
  logic          flush;
  logic [CW-1:0] count;
  logic          almost_full, almost_empty;

  int checks = 0;
  int errors = 0;

  stream_fifo #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .AFULL_LEVEL  (AFULL),
    .AEMPTY_LEVEL (AEMPTY)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .io_enq_valid    (enq_valid),
    .io_enq_ready    (enq_ready),
    .io_enq_data     (enq_data),
    .io_deq_valid    (deq_valid),
    .io_deq_ready    (deq_ready),
    .io_deq_data     (deq_data),
    .io_flush        (flush),
    .io_count        (count),
    .io_almost_full  (almost_full),
    .io_almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a queue of stored words -------------
  logic [DW-1:0] model_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q.delete();
    end else begin
      bit can_enq, can_deq;
      can_enq = enq_valid && (model_q.size() < DEPTH);
      can_deq = deq_ready && (model_q.size() > 0);
      if (flush) begin
        model_q.delete();
      end else begin
        if (can_deq) void'(model_q.pop_front());
        if (can_enq) model_q.push_back(enq_data);
      end
    end
  end

  // Compare process: outputs are state-only, so check them mid-cycle.
  always @(negedge clk) begin
    int n;
    n = model_q.size();
    check("cmp_enq_ready",    32'(enq_ready),    32'(n < DEPTH));
    check("cmp_deq_valid",    32'(deq_valid),    32'(n > 0));
    check("cmp_count",        32'(count),        32'(n));
    check("cmp_almost_full",  32'(almost_full),  32'(n >= AFULL));
    check("cmp_almost_empty", 32'(almost_empty), 32'(n <= AEMPTY));
    if (n > 0) check("cmp_deq_data", 32'(deq_data), 32'(model_q[0]));
  end

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enq_ready"},    32'(enq_ready),    32'd1);
    check({tag, "_deq_valid"},    32'(deq_valid),    32'd0);
    check({tag, "_count"},        32'(count),        32'd0);
    check({tag, "_almost_full"},  32'(almost_full),  32'd0);
    check({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
  endtask

  task automatic fill_four();
    logic [DW-1:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1'b1;
      enq_data  = vals[i];
      step();
    end
    enq_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] vals [4];
    logic          af_exp [4];
    logic          ae_exp [4];
    logic [DW-1:0] stream [20];

    vals   = '{8'h11, 8'h22, 8'h33, 8'h44};
    af_exp = '{1'b0, 1'b0, 1'b1, 1'b1};
    ae_exp = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 20; i++) stream[i] = 8'(i * 37 + 5);

    idle_inputs();
    reset = 1'b0;
    #2;
    check_reset_outputs("rst_held");
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    // 1. reset then idle
    step();
    check_reset_outputs("t1_idle");

    // 2. fill and drain in order
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1'b1;
      enq_data  = vals[i];
      step();
      check($sformatf("t2_count_%0d", i), 32'(count), 32'(i + 1));
      check($sformatf("t2_afull_%0d", i), 32'(almost_full), 32'(af_exp[i]));
      check($sformatf("t2_aempty_%0d", i), 32'(almost_empty), 32'(ae_exp[i]));
    end
    enq_valid = 1'b0;
    check("t2_enq_ready_full", 32'(enq_ready), 32'd0);
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_deq_valid_%0d", i), 32'(deq_valid), 32'd1);
      check($sformatf("t2_deq_data_%0d", i), 32'(deq_data), 32'(vals[i]));
      step();
    end
    check("t2_drained", 32'(deq_valid), 32'd0);
    deq_ready = 1'b0;

    // 3. full stall: no bypass of a concurrent deq into a full FIFO
    fill_four();
    check("t3_full_count", 32'(count), 32'd4);
    enq_valid = 1'b1;
    enq_data  = 8'h55;
    deq_ready = 1'b1;
    check("t3_head_11", 32'(deq_data), 32'h11);
    step();
    check("t3_count_after_stall", 32'(count), 32'd3);
    deq_ready = 1'b0;
    step();
    check("t3_count_55_taken", 32'(count), 32'd4);
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    vals = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_order_%0d", i), 32'(deq_data), 32'(vals[i]));
      step();
    end
    check("t3_drained", 32'(deq_valid), 32'd0);
    deq_ready = 1'b0;

    // 4. concurrent streaming across several pointer wraps
    enq_valid = 1'b1;
    enq_data  = stream[0];
    step();
    deq_ready = 1'b1;
    for (int i = 1; i < 20; i++) begin
      check($sformatf("t4_count_%0d", i), 32'(count), 32'd1);
      check($sformatf("t4_data_%0d", i), 32'(deq_data), 32'(stream[i-1]));
      enq_data = stream[i];
      step();
    end
    enq_valid = 1'b0;
    check("t4_last_data", 32'(deq_data), 32'(stream[19]));
    step();
    check("t4_drained", 32'(deq_valid), 32'd0);
    deq_ready = 1'b0;

    // 5. flush overrides concurrent enq and deq
    enq_valid = 1'b1;
    enq_data  = 8'h61;
    step();
    enq_data  = 8'h62;
    step();
    check("t5_count_2", 32'(count), 32'd2);
    flush     = 1'b1;
    enq_data  = 8'h77;
    deq_ready = 1'b1;
    #1;
    check("t5_preflush_enq_ready", 32'(enq_ready), 32'd1);
    check("t5_preflush_deq_valid", 32'(deq_valid), 32'd1);
    step();
    idle_inputs();
    check("t5_flushed_count", 32'(count), 32'd0);
    check("t5_flushed_deq_valid", 32'(deq_valid), 32'd0);
    enq_valid = 1'b1;
    enq_data  = 8'h88;
    step();
    enq_valid = 1'b0;
    check("t5_first_after_flush", 32'(deq_data), 32'h88);
    check("t5_count_1", 32'(count), 32'd1);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;

    // 6. asynchronous reset between edges
    enq_valid = 1'b1;
    enq_data  = 8'hA1;
    step();
    enq_data  = 8'hA2;
    step();
    enq_data  = 8'hA3;
    step();
    enq_valid = 1'b0;
    check("t6_count_3", 32'(count), 32'd3);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    #2 reset = 1'b1;
    step();
    enq_valid = 1'b1;
    enq_data  = 8'h99;
    step();
    enq_valid = 1'b0;
    check("t6_data_99", 32'(deq_data), 32'h99);
    check("t6_count_1", 32'(count), 32'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
